mux_sweep_ctrl: RTL and testbench

Sequencing stage that drives the combinational `spec_mux` select decoder and collects its single-bit output. On a `start` pulse it:

- latches a 4-bit input word;
- steps `mux_sel` through 0..7, holding each value for a programmable dwell;
- samples `mux_out` once per step and packs the eight samples into an 8-bit result.

The result is presented on a valid/ready handshake. It sits directly around the mux: it feeds `inp`/`sel` and consumes `out`.

---
 rtl/mux_sweep_pkg.sv | 14 +
 rtl/mux_sweep_dwell_cnt.sv | 27 ++
 rtl/mux_sweep_ctrl.sv | 103 ++++++++++
 tb/tb_mux_sweep_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_sweep_pkg.sv
// Shared types and default widths for the mux sweep sequencer.
package mux_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  localparam int SWEEP_SEL_W = 3;
  localparam int SWEEP_INP_W = 4;
  localparam int SWEEP_RES_W = 8;

endpackage

// File: rtl/mux_sweep_dwell_cnt.sv
// Per-step dwell counter: flags the last cycle a select value is held.
module mux_sweep_dwell_cnt
  import mux_sweep_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  // One spare bit so DWELL-1 always fits and the count never wraps in a step.
  localparam int CW = $clog2(DWELL) + 1;

  logic [CW-1:0] cnt;

  // Count cycles spent on the current select; cleared on step advance or start.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end

  assign last = (cnt == CW'(DWELL - 1));

endmodule

// File: rtl/mux_sweep_ctrl.sv
// Sweeps mux_sel across every select value of an external combinational mux,
// sampling mux_out once per step into a result word offered on valid/ready.
// Optional: define MUX_SWEEP_PARITY_EN to add the result_par output.
module mux_sweep_ctrl
  import mux_sweep_pkg::*;
#(
  parameter int DWELL = 1,
  parameter int SEL_W = SWEEP_SEL_W,
  parameter int INP_W = SWEEP_INP_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [INP_W-1:0]        inp_in,
  output logic                    busy,
  output logic [INP_W-1:0]        mux_inp,
  output logic [SEL_W-1:0]        mux_sel,
  input  logic                    mux_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [(1<<SEL_W)-1:0]   result
`ifdef MUX_SWEEP_PARITY_EN
  ,
  output logic                    result_par
`endif
);

  localparam int RES_W = 1 << SEL_W;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_DRIVE = DRIVE;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]       state;
  logic             accept;
  logic             step_last;
  logic             sweep_end;
  logic [RES_W-1:0] res_next;

  assign accept    = (state == ST_IDLE) && start;
  assign sweep_end = (state == ST_DRIVE) && step_last && (&mux_sel);

  mux_sweep_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept || ((state == ST_DRIVE) && step_last)),
    .en   (state == ST_DRIVE),
    .last (step_last)
  );

  // Result with the current sample merged in; used for both the register and parity.
  always_comb begin
    res_next          = result;
    res_next[mux_sel] = mux_out;
  end

  // Sweep FSM, select stepping and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mux_sel <= '0;
      mux_inp <= '0;
      result  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mux_inp <= inp_in;
            result  <= '0;
            mux_sel <= '0;
            state   <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (step_last) begin
            result <= res_next;
            if (&mux_sel) state   <= ST_DONE;
            else          mux_sel <= mux_sel + 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MUX_SWEEP_PARITY_EN
  // Parity is taken over the completed word so it lands with the final sample.
  always_ff @(posedge clk) begin
    if (rst || accept) result_par <= 1'b0;
    else if (sweep_end) result_par <= ^res_next;
  end
`else
  logic unused_sweep_end;
  assign unused_sweep_end = sweep_end;
`endif

  assign busy      = (state != ST_IDLE);
  assign res_valid = (state == ST_DONE);

endmodule

// File: tb/tb_mux_sweep_ctrl.sv
// Scoreboard bench for mux_sweep_ctrl: two instances (DWELL=1 and DWELL=3)
// sweep a bench-side mux modelled as a truth table indexed by word and select.
module tb_mux_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s [2];
  logic [3:0] inp_s   [2];
  logic       ready_s [2];
  logic       busy_o  [2];
  logic       valid_o [2];
  logic [3:0] minp_o  [2];
  logic [2:0] msel_o  [2];
  logic       mout    [2];
  logic [7:0] res_o   [2];
  logic       par_o   [2];

  // Mux truth table: bit k of tbl[w] is the mux output for word w, select k.
  logic [7:0] tbl [16];

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  assign mout[0] = tbl[minp_o[0]][msel_o[0]];
  assign mout[1] = tbl[minp_o[1]][msel_o[1]];

  mux_sweep_ctrl #(.DWELL(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_s[0]), .inp_in(inp_s[0]), .busy(busy_o[0]),
    .mux_inp(minp_o[0]), .mux_sel(msel_o[0]), .mux_out(mout[0]),
    .res_valid(valid_o[0]), .res_ready(ready_s[0]), .result(res_o[0])
`ifdef MUX_SWEEP_PARITY_EN
    , .result_par(par_o[0])
`endif
  );

  mux_sweep_ctrl #(.DWELL(3)) u_d3 (
    .clk(clk), .rst(rst), .start(start_s[1]), .inp_in(inp_s[1]), .busy(busy_o[1]),
    .mux_inp(minp_o[1]), .mux_sel(msel_o[1]), .mux_out(mout[1]),
    .res_valid(valid_o[1]), .res_ready(ready_s[1]), .result(res_o[1])
`ifdef MUX_SWEEP_PARITY_EN
    , .result_par(par_o[1])
`endif
  );

`ifndef MUX_SWEEP_PARITY_EN
  initial begin
    par_o[0] = 1'b0;
    par_o[1] = 1'b0;
  end
`endif

  function automatic int dw(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp_v);
    ncmp++;
    if (act !== exp_v) begin
      nfail++;
      $display("FAIL %s[%0d] t=%0t got %0h expected %0h", nm, i, $time, act, exp_v);
    end
  endtask

  // Reference model: 0 idle, 1 sweeping, 2 holding result. mk = edges since accept.
  int         ms     [2];
  int         mk     [2];
  logic [2:0] msel   [2];
  logic [3:0] minp   [2];
  logic       mclean [2];
  logic [8:0] exp_q  [2][$];
  logic       armed = 1'b0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      ms[i] = 0; mk[i] = 0; msel[i] = '0; minp[i] = '0; mclean[i] = 1'b1;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ms[i] <= 0; mk[i] <= 0; msel[i] <= '0; minp[i] <= '0; mclean[i] <= 1'b1;
        exp_q[i].delete();
        armed <= 1'b1;
      end else begin
        case (ms[i])
          0: if (start_s[i]) begin
               ms[i] <= 1; mk[i] <= 0; msel[i] <= '0; minp[i] <= inp_s[i]; mclean[i] <= 1'b0;
               exp_q[i].push_back({^tbl[inp_s[i]], tbl[inp_s[i]]});
             end
          1: begin
               mk[i] <= mk[i] + 1;
               if (mk[i] + 1 == 8 * dw(i)) ms[i] <= 2;
               else msel[i] <= 3'((mk[i] + 1) / dw(i));
             end
          default: if (ready_s[i]) ms[i] <= 0;
        endcase
      end
    end
  end

  // Monitor: compare observable state every cycle, pop the scoreboard on handshake.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk("busy", i, 32'(busy_o[i]), 32'(ms[i] != 0));
        chk("res_valid", i, 32'(valid_o[i]), 32'(ms[i] == 2));
        chk("mux_sel", i, 32'(msel_o[i]), 32'(msel[i]));
        chk("mux_inp", i, 32'(minp_o[i]), 32'(minp[i]));
        if (ms[i] == 0 && mclean[i]) chk("result_reset", i, 32'(res_o[i]), 32'h0);
        if (valid_o[i] === 1'b1) begin
          if (exp_q[i].size() == 0) begin
            chk("result_unexpected", i, 32'(res_o[i]), 32'hFFFF_FFFF);
          end else begin
            chk("result", i, 32'(res_o[i]), 32'(exp_q[i][0][7:0]));
`ifdef MUX_SWEEP_PARITY_EN
            chk("result_par", i, 32'(par_o[i]), 32'(exp_q[i][0][8]));
`endif
            if (ready_s[i]) void'(exp_q[i].pop_front());
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n = 0;
    while (ms[i] != 0 && n < budget) begin cyc(); n++; end
    if (ms[i] != 0) chk("timeout_idle", i, 32'(ms[i]), 32'h0);
  endtask

  task automatic pulse(input int i, input logic [3:0] w);
    inp_s[i] = w; start_s[i] = 1'b1;
    cyc();
    start_s[i] = 1'b0;
  endtask

  initial begin
    int n;
    for (int x = 0; x < 16; x++) tbl[x] = 8'($urandom);
    tbl[9] = 8'hDC; tbl[1] = 8'h40; tbl[8] = 8'hDC;
    for (int i = 0; i < 2; i++) begin start_s[i] = 1'b0; inp_s[i] = '0; ready_s[i] = 1'b1; end
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // Directed sweeps with known answers on both dwell settings.
    inp_s[1] = 4'b1000; start_s[1] = 1'b1;
    pulse(0, 4'b1001);
    start_s[1] = 1'b0;
    wait_idle(0, 40);
    pulse(0, 4'b0001);
    wait_idle(0, 40);
    wait_idle(1, 80);

    // Backpressure with an ignored start, then start coinciding with the handshake.
    ready_s[0] = 1'b0;
    pulse(0, 4'($urandom));
    n = 0;
    while (ms[0] != 2 && n < 40) begin cyc(); n++; end
    if (ms[0] != 2) chk("timeout_done", 0, 32'(ms[0]), 32'h2);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin inp_s[0] = 4'($urandom); start_s[0] = 1'b1; end
      else start_s[0] = 1'b0;
      cyc();
    end
    ready_s[0] = 1'b1; start_s[0] = 1'b1;
    cyc();
    start_s[0] = 1'b0;
    cyc();

    // Abort mid-sweep, then a clean sweep.
    pulse(0, 4'($urandom));
    n = 0;
    while (msel[0] != 3'd4 && n < 40) begin cyc(); n++; end
    if (msel[0] != 3'd4) chk("timeout_sel4", 0, 32'(msel[0]), 32'h4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    pulse(0, 4'b1001);
    wait_idle(0, 40);

    // Back-to-back with start held and ready tied high.
    ready_s[0] = 1'b1; start_s[0] = 1'b1;
    for (int c = 0; c < 60; c++) begin inp_s[0] = 4'($urandom); cyc(); end
    start_s[0] = 1'b0;

    // Random traffic on both instances.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        start_s[i] = ($urandom_range(3) == 0);
        inp_s[i]   = 4'($urandom);
        ready_s[i] = ($urandom_range(2) != 0);
      end
      cyc();
    end

    // Drain and confirm every expected result was delivered.
    for (int i = 0; i < 2; i++) begin start_s[i] = 1'b0; ready_s[i] = 1'b1; end
    repeat (60) cyc();
    for (int i = 0; i < 2; i++) chk("queue_drained", i, 32'(exp_q[i].size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
